spi_cfg_arbiter: RTL and testbench
==================================

SPI_CFG_ARBITER -- requirements
Module: spi_cfg_arbiter

Interface
REQ-001 Parameters SHALL be:
- ROM_AW, default 6: init-table address width.
- EN_HOLD, default 3: spi_clk cycles the master enable is held high.
- TIMEOUT, default 1023: max cycles from enable rise to m_finish.
- RD_SETTLE, default 2: cycles from m_finish to m_dout capture.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- spi_clk, in, 1: sole clock, rising edge.
- spi_reset_n, in, 1: asynchronous, active-low reset.
- init_start, in, 1: one-cycle pulse that starts table playback.
- init_busy, out, 1: playback in progress.
- init_done, out, 1: level; playback completed cleanly.
- init_err, out, 1: level; playback aborted on timeout.
- rom_addr, out, ROM_AW: init-table index.
- rom_data, in, 24: [23]=last, [22:8]=addr, [7:0]=data; valid 1 cycle after rom_addr.
- host_req, in, 1: level; held until host_ack.
- host_rd, in, 1: 1=read, 0=write.
- host_addr, in, 15: host register address.
- host_wdata, in, 8: host write data.
- host_ack, out, 1: one-cycle completion pulse.
- host_rdata, out, 8: read result, valid with host_ack.
- host_err, out, 1: valid with host_ack; 1=timeout.
- m_wr_en, out, 1: SPI master write enable.
- m_rd_en, out, 1: SPI master read enable.
- m_cmd, out, 1: R/W bit to master; 1=read, 0=write.
- m_addr, out, 15: SPI master address.
- m_din, out, 8: SPI master write data.
- m_dout, in, 8: SPI master read data.
- m_finish, in, 1: SPI master completion pulse.
REQ-003 The block SHALL use one clock domain (spi_clk) with asynchronous, active-low reset spi_reset_n.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT_FIN, SETTLE, RESP.
REQ-005 IDLE SHALL grant one transaction at a time from two requesters, INIT (pending while init_busy) and HOST (host_req high); when both are pending, grant SHALL alternate, starting with INIT after reset.
REQ-006 INIT grant SHALL go IDLE->FETCH: drive rom_addr, wait 1 cycle, latch the rom_data fields; HOST grant SHALL go IDLE->ISSUE and latch host_addr/host_wdata/host_rd.
REQ-007 ISSUE SHALL drive m_addr/m_din/m_cmd from the latch and hold exactly one of m_wr_en/m_rd_en high for EN_HOLD cycles, then low, then enter WAIT_FIN; INIT entries SHALL always be writes.
REQ-008 m_addr/m_din/m_cmd SHALL stay stable from ISSUE entry until the state returns to IDLE.
REQ-009 WAIT_FIN SHALL count cycles from enable rise; m_finish high SHALL go to SETTLE (read) or RESP (write); a count reaching TIMEOUT SHALL go to RESP with the error flag set.
REQ-010 SETTLE SHALL wait RD_SETTLE cycles, then capture m_dout into host_rdata.
REQ-011 RESP, for HOST, SHALL pulse host_ack for one cycle with host_err; host_rdata SHALL hold its last captured value otherwise.
REQ-012 RESP, for INIT, SHALL behave as follows:
- error: clear init_busy, set init_err.
- last=1: clear init_busy, set init_done.
- otherwise: increment rom_addr.
- in all cases: return to IDLE.
REQ-013 rom_addr SHALL wrap from all-ones to 0 without error; a table with no last bit SHALL loop until init_start is re-pulsed or reset.
REQ-014 init_start SHALL set init_busy, clear init_done/init_err, and zero rom_addr; if a transaction is in flight, the restart SHALL take effect at its RESP, and that transaction SHALL complete unaffected.
REQ-015 A host_req that drops before host_ack SHALL not abort an issued transaction; the ack SHALL still pulse.
REQ-016 A gap of at least 2 cycles SHALL separate consecutive enable rises (the master edge-detects through two flops).

Reset
REQ-017 On spi_reset_n low, the block SHALL:
- enter IDLE;
- drive all outputs 0 (rom_addr=0, host_rdata=0, m_* = 0);
- clear counters and grant pointer to INIT;
- take effect immediately and asynchronously, including mid-transaction.

Structure
REQ-018 A shared package (spi_cfg_pkg) SHALL hold the FSM state encoding, the rom_data field positions, and the default parameter values.
REQ-019 One sub-module, spi_cfg_timer (load/enable/expire counter), SHALL be shared by EN_HOLD, TIMEOUT and RD_SETTLE counting.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Init playback: table {0x0003/0x81, 0x0010/0x5A (last)} -> exactly 2 write transactions, m_cmd=0 on both, init_done=1, init_err=0.
- Host read: host_addr=0x0123 with master model returning 0xA5 -> m_rd_en high 3 cycles, m_cmd=1, host_ack with host_rdata=0xA5 and host_err=0.
- Contention: init busy with a 3-entry table, host write pending -> grant order INIT, HOST, INIT, INIT.
- Timeout: m_finish never pulsed -> host_ack with host_err=1 at 1023 cycles after enable rise; same case during init -> init_err=1, init_busy=0.
- Reset mid-WAIT_FIN: spi_reset_n low -> all outputs 0 asynchronously; after release, the next host_req completes normally.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration arbiter: FSM encoding, init-table
// field layout and default parameter values.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_SETTLE   = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  typedef enum logic {
    OWN_INIT = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // rom_data layout: [23]=last, [22:8]=register address, [7:0]=write data
  localparam int ROM_DW       = 24;
  localparam int ROM_LAST_BIT = 23;
  localparam int ROM_ADDR_MSB = 22;
  localparam int ROM_ADDR_LSB = 8;
  localparam int ROM_DATA_MSB = 7;
  localparam int ROM_DATA_LSB = 0;

  localparam int REG_AW = 15;
  localparam int REG_DW = 8;

  localparam int DEF_ROM_AW    = 6;
  localparam int DEF_EN_HOLD   = 3;
  localparam int DEF_TIMEOUT   = 1023;
  localparam int DEF_RD_SETTLE = 2;

endpackage

// File: rtl/spi_cfg_timer.sv
// Down-counter shared by the enable-hold, finish-timeout and read-settle phases.
// Loaded with N on state entry, expire_o flags the last of those N cycles.
module spi_cfg_timer #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q <= W'(1));

endmodule

// File: rtl/spi_cfg_arbiter.sv
// Arbitrates an init-table player and a host port onto one SPI master,
// one transaction at a time with alternating grant under contention.
module spi_cfg_arbiter
  import spi_cfg_pkg::*;
#(
  parameter int ROM_AW    = DEF_ROM_AW,
  parameter int EN_HOLD   = DEF_EN_HOLD,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int RD_SETTLE = DEF_RD_SETTLE
) (
  input  logic              spi_clk,
  input  logic              spi_reset_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data,
  input  logic              host_req,
  input  logic              host_rd,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [REG_DW-1:0] host_wdata,
  output logic              host_ack,
  output logic [REG_DW-1:0] host_rdata,
  output logic              host_err,
  output logic              m_wr_en,
  output logic              m_rd_en,
  output logic              m_cmd,
  output logic [REG_AW-1:0] m_addr,
  output logic [REG_DW-1:0] m_din,
  input  logic [REG_DW-1:0] m_dout,
  input  logic              m_finish,
  output logic [2:0]        dbg_state
);

  localparam int TMAX_A   = (TIMEOUT > EN_HOLD) ? TIMEOUT : EN_HOLD;
  localparam int TMAX     = (TMAX_A > RD_SETTLE) ? TMAX_A : RD_SETTLE;
  localparam int TW       = $clog2(TMAX + 1);
  // WAIT_FIN continues the count started at enable rise, so it only gets the remainder
  localparam int WAIT_LEN = (TIMEOUT > EN_HOLD) ? (TIMEOUT - EN_HOLD) : 1;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              ptr_q, ptr_d;
  logic [REG_AW-1:0]   addr_q, addr_d;
  logic [REG_DW-1:0]   din_q, din_d;
  logic                cmd_q, cmd_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                en_q, en_d;
  logic [REG_DW-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ierr_q, ierr_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                restart_q, restart_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_expire;

  spi_cfg_timer #(.W(TW)) u_timer (
    .clk_i      (spi_clk),
    .rst_ni     (spi_reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (1'b1),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cmd_d      = cmd_q;
    last_d     = last_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ierr_d     = ierr_q;
    rom_addr_d = rom_addr_q;
    restart_d  = restart_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    // A restart arriving mid-transaction is parked until that transaction's RESP
    if (init_start && (state_q != S_IDLE)) restart_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          ierr_d     = 1'b0;
          rom_addr_d = '0;
        end else if (busy_q && (!host_req || (ptr_q == OWN_INIT))) begin
          owner_d = OWN_INIT;
          ptr_d   = OWN_HOST;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end else if (host_req) begin
          owner_d  = OWN_HOST;
          ptr_d    = OWN_INIT;
          err_d    = 1'b0;
          addr_d   = host_addr;
          din_d    = host_wdata;
          cmd_d    = host_rd;
          last_d   = 1'b0;
          state_d  = S_ISSUE;
          tmr_load = 1'b1;
          tmr_val  = TW'(EN_HOLD);
        end
      end
      S_FETCH: begin
        addr_d   = rom_data[ROM_ADDR_MSB:ROM_ADDR_LSB];
        din_d    = rom_data[ROM_DATA_MSB:ROM_DATA_LSB];
        last_d   = rom_data[ROM_LAST_BIT];
        cmd_d    = 1'b0;
        state_d  = S_ISSUE;
        tmr_load = 1'b1;
        tmr_val  = TW'(EN_HOLD);
      end
      S_ISSUE: begin
        if (tmr_expire) begin
          state_d  = S_WAIT_FIN;
          tmr_load = 1'b1;
          tmr_val  = TW'(WAIT_LEN);
        end
      end
      S_WAIT_FIN: begin
        if (m_finish) begin
          if (cmd_q) begin
            state_d  = S_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = TW'(RD_SETTLE);
          end else begin
            state_d = S_RESP;
          end
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_SETTLE: begin
        if (tmr_expire) begin
          rdata_d = m_dout;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (init_start || restart_q) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          ierr_d     = 1'b0;
          rom_addr_d = '0;
          restart_d  = 1'b0;
        end else if (owner_q == OWN_INIT) begin
          if (err_q) begin
            busy_d = 1'b0;
            ierr_d = 1'b1;
          end else if (last_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + ROM_AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign en_d = (state_d == S_ISSUE);

  always_ff @(posedge spi_clk or negedge spi_reset_n) begin
    if (!spi_reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_INIT;
      ptr_q      <= OWN_INIT;
      addr_q     <= '0;
      din_q      <= '0;
      cmd_q      <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ierr_q     <= 1'b0;
      rom_addr_q <= '0;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cmd_q      <= cmd_d;
      last_q     <= last_d;
      err_q      <= err_d;
      en_q       <= en_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ierr_q     <= ierr_d;
      rom_addr_q <= rom_addr_d;
      restart_q  <= restart_d;
    end
  end

  assign init_busy  = busy_q;
  assign init_done  = done_q;
  assign init_err   = ierr_q;
  assign rom_addr   = rom_addr_q;
  assign host_ack   = (state_q == S_RESP) && (owner_q == OWN_HOST);
  assign host_err   = host_ack & err_q;
  assign host_rdata = rdata_q;
  assign m_wr_en    = en_q & ~cmd_q;
  assign m_rd_en    = en_q & cmd_q;
  assign m_cmd      = cmd_q;
  assign m_addr     = addr_q;
  assign m_din      = din_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Bench for spi_cfg_arbiter: ROM and SPI master models, transaction scoreboard,
// directed scenarios plus randomized host/init traffic.
module tb_spi_cfg_arbiter;

  localparam int ROM_AW    = 6;
  localparam int ROM_DEPTH = 1 << ROM_AW;
  localparam int EN_HOLD   = 3;
  localparam int TIMEOUT   = 1023;
  localparam int RD_SETTLE = 2;

  logic              spi_clk = 1'b0;
  logic              spi_reset_n;
  logic              init_start;
  logic              init_busy, init_done, init_err;
  logic [ROM_AW-1:0] rom_addr;
  logic [23:0]       rom_data = '0;
  logic              host_req, host_rd;
  logic [14:0]       host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack, host_err;
  logic [7:0]        host_rdata;
  logic              m_wr_en, m_rd_en, m_cmd;
  logic [14:0]       m_addr;
  logic [7:0]        m_din;
  logic [7:0]        m_dout = '0;
  logic              m_finish = 1'b0;
  logic [2:0]        dbg_state;

  spi_cfg_arbiter #(
    .ROM_AW(ROM_AW), .EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT), .RD_SETTLE(RD_SETTLE)
  ) dut (
    .spi_clk(spi_clk), .spi_reset_n(spi_reset_n), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .host_req(host_req), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .m_wr_en(m_wr_en), .m_rd_en(m_rd_en), .m_cmd(m_cmd), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout), .m_finish(m_finish), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 spi_clk = ~spi_clk;

  int cyc = 0;
  always @(posedge spi_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];          // {is_read, addr, wdata} per master transaction
  logic [23:0] rom [0:ROM_DEPTH-1];
  logic [7:0]  last_rdata = '0;
  int          fin_delay = 0;     // cycles after WAIT_FIN entry; negative = never finish
  logic [7:0]  rd_val = '0;
  int          n_rise = 0;
  int          rise_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- ROM model: data valid one cycle after address ----------------
  always @(posedge spi_clk) rom_data <= rom[rom_addr];

  // ---------------- master model + transaction monitor ----------------
  logic        prev_en = 1'b0;
  int          hold = 0;
  int          fall_cyc = -1000;
  int          fin_cnt = -1;
  int          dout_cnt = -1;
  logic [23:0] rec_at_rise = '0;

  always @(negedge spi_clk) begin : monitor
    logic en;
    logic has_exp;
    if (!spi_reset_n) begin
      prev_en  = 1'b0;
      hold     = 0;
      fin_cnt  = -1;
      dout_cnt = -1;
      m_finish = 1'b0;
      fall_cyc = -1000;
    end else begin
      en = m_wr_en | m_rd_en;
      m_finish = 1'b0;
      if (en && !prev_en) begin
        n_rise++;
        rise_cyc = cyc;
        check_eq("en_gap_ge2", 64'((cyc - fall_cyc) >= 2), 64'd1);
        check_eq("one_enable", 64'(m_wr_en & m_rd_en), 64'd0);
        check_eq("cmd_vs_rd_en", 64'(m_cmd), 64'(m_rd_en));
        rec_at_rise = {m_cmd, m_addr, m_din};
        has_exp = (exp_q.size() != 0);
        check_eq("xact_expected", 64'(has_exp), 64'd1);
        if (has_exp) check_eq("xact_fields", 64'(rec_at_rise), 64'(exp_q.pop_front()));
        hold = 1;
        fin_cnt = (fin_delay < 0) ? -1 : (EN_HOLD + fin_delay);
      end else begin
        if (en) hold++;
        if (fin_cnt > 0) begin
          fin_cnt--;
          if (fin_cnt == 0) begin
            m_finish = 1'b1;
            dout_cnt = 0;
            fin_cnt  = -1;
          end
        end
      end
      if (!en && prev_en) begin
        check_eq("en_hold_cycles", 64'(hold), 64'(EN_HOLD));
        check_eq("m_fields_stable", 64'({m_cmd, m_addr, m_din}), 64'(rec_at_rise));
        fall_cyc = cyc;
      end
      // read data is only correct exactly RD_SETTLE cycles after m_finish
      if (dout_cnt >= 0) begin
        m_dout = (dout_cnt == RD_SETTLE) ? rd_val : ~rd_val;
        dout_cnt++;
        if (dout_cnt > RD_SETTLE + 1) dout_cnt = -1;
      end
      prev_en = en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge spi_clk);
    spi_reset_n = 1'b0;
    host_req = 1'b0;
    init_start = 1'b0;
    repeat (2) @(negedge spi_clk);
    spi_reset_n = 1'b1;
    last_rdata = '0;
  endtask

  task automatic wait_ack(output logic [7:0] rdata, output logic err, output int lat);
    bit got = 0;
    rdata = '0; err = 1'b0; lat = -1;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge spi_clk);
      if (host_ack) begin
        got = 1;
        rdata = host_rdata;
        err = host_err;
        lat = cyc - rise_cyc;
        host_req = 1'b0;
      end
    end
    check_eq("host_ack_seen", 64'(got), 64'd1);
    if (!got) host_req = 1'b0;
  endtask

  task automatic host_xact(input logic rd, input logic [14:0] addr, input logic [7:0] wdata,
                           input logic [7:0] dout, input int fdelay, input bit early_drop);
    logic [7:0] rdv;
    logic       erv;
    int         lat;
    int         base;
    logic [7:0] exp_rd;
    fin_delay = fdelay;
    rd_val = dout;
    base = n_rise;
    @(negedge spi_clk);
    host_rd = rd; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    exp_q.push_back({rd, addr, wdata});
    if (early_drop) begin
      for (int n = 0; n < 100 && n_rise == base; n++) @(negedge spi_clk);
      host_req = 1'b0;
    end
    wait_ack(rdv, erv, lat);
    exp_rd = (rd && fdelay >= 0) ? dout : last_rdata;
    check_eq("host_err", 64'(erv), 64'(fdelay < 0));
    check_eq("host_rdata", 64'(rdv), 64'(exp_rd));
    last_rdata = exp_rd;
    if (fdelay < 0) check_eq("timeout_latency", 64'(lat), 64'(TIMEOUT));
    @(negedge spi_clk);
    check_eq("ack_one_cycle", 64'(host_ack), 64'd0);
  endtask

  // Reference: walk the table from entry 0 until a last bit, wrapping the index
  task automatic push_init_model(input int max_n);
    int a = 0;
    for (int k = 0; k < max_n; k++) begin
      exp_q.push_back({1'b0, rom[a][22:8], rom[a][7:0]});
      if (rom[a][23]) break;
      a = (a + 1) % ROM_DEPTH;
    end
  endtask

  task automatic pulse_init();
    @(negedge spi_clk);
    init_start = 1'b1;
    @(negedge spi_clk);
    init_start = 1'b0;
  endtask

  task automatic wait_init_idle();
    bit got = 0;
    for (int n = 0; n < 5000 && !got; n++) begin
      @(negedge spi_clk);
      if (!init_busy) got = 1;
    end
    check_eq("init_finished", 64'(got), 64'd1);
  endtask

  task automatic init_check(input bit exp_err);
    check_eq("init_busy", 64'(init_busy), 64'd0);
    check_eq("init_done", 64'(init_done), 64'(!exp_err));
    check_eq("init_err", 64'(init_err), 64'(exp_err));
    check_eq("init_xacts_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_table(input int len);
    for (int i = 0; i < len; i++) begin
      rom[i] = {1'b0, 15'($urandom_range(0, 32767)), 8'($urandom_range(0, 255))};
    end
    rom[len-1][23] = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rdv;
    logic       erv;
    int         lat;
    int         base;
    bit         marked;
    logic [14:0] a15;
    logic [7:0]  d8;

    spi_reset_n = 1'b0;
    init_start = 1'b0;
    host_req = 1'b0; host_rd = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
    repeat (3) @(negedge spi_clk);
    check_eq("reset_outputs", 64'({init_busy, init_done, init_err, rom_addr, host_ack, host_err,
             host_rdata, m_wr_en, m_rd_en, m_cmd, m_addr, m_din}), 64'd0);
    spi_reset_n = 1'b1;

    // directed init playback
    fin_delay = 3;
    rom[0] = {1'b0, 15'h0003, 8'h81};
    rom[1] = {1'b1, 15'h0010, 8'h5A};
    push_init_model(8);
    check_eq("init_model_len", 64'(exp_q.size()), 64'd2);
    pulse_init();
    wait_init_idle();
    init_check(1'b0);

    // directed host read, then a write
    host_xact(1'b1, 15'h0123, 8'h00, 8'hA5, 2, 1'b0);
    host_xact(1'b0, 15'h2222, 8'h5C, 8'h00, 0, 1'b0);

    // timeouts: host, then init
    host_xact(1'b1, 15'h0456, 8'h00, 8'h99, -1, 1'b0);
    fin_delay = -1;
    rom[0] = {1'b0, 15'h0042, 8'h11};
    exp_q.push_back({1'b0, 15'h0042, 8'h11});
    pulse_init();
    wait_init_idle();
    init_check(1'b1);
    check_eq("init_err_rom_addr", 64'(rom_addr), 64'd0);

    // randomized mix
    for (int it = 0; it < 10; it++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (sel == 2) begin
        fin_delay = $urandom_range(0, 6);
        fill_table($urandom_range(1, 4));
        push_init_model(8);
        pulse_init();
        wait_init_idle();
        init_check(1'b0);
      end else begin
        host_xact(sel == 0, 15'($urandom_range(0, 32767)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end
    end

    // restart while an init transaction is in flight
    fin_delay = 5;
    fill_table(3);
    for (int k = 0; k < 2; k++) exp_q.push_back({1'b0, rom[k][22:8], rom[k][7:0]});
    push_init_model(8);
    base = n_rise;
    pulse_init();
    for (int n = 0; n < 200 && n_rise < base + 2; n++) @(negedge spi_clk);
    check_eq("restart_at_second", 64'(n_rise - base), 64'd2);
    pulse_init();
    wait_init_idle();
    init_check(1'b0);

    // table without a last bit wraps; mark entry 2 once the first pass is past it
    fin_delay = 0;
    for (int i = 0; i < ROM_DEPTH; i++)
      rom[i] = {1'b0, 15'($urandom_range(0, 32767)), 8'($urandom_range(0, 255))};
    for (int i = 0; i < ROM_DEPTH; i++) exp_q.push_back({1'b0, rom[i][22:8], rom[i][7:0]});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, rom[i][22:8], rom[i][7:0]});
    base = n_rise;
    marked = 0;
    pulse_init();
    for (int n = 0; n < 3000 && init_busy; n++) begin
      @(negedge spi_clk);
      if (!marked && (n_rise - base) >= 10) begin
        rom[2][23] = 1'b1;
        marked = 1;
      end
    end
    check_eq("wrap_xact_count", 64'(n_rise - base), 64'(ROM_DEPTH + 3));
    init_check(1'b0);

    // contention after reset: INIT, HOST, INIT, INIT
    do_reset();
    fin_delay = 2;
    fill_table(3);
    a15 = 15'($urandom_range(0, 32767));
    d8 = 8'($urandom_range(0, 255));
    exp_q.push_back({1'b0, rom[0][22:8], rom[0][7:0]});
    exp_q.push_back({1'b0, a15, d8});
    exp_q.push_back({1'b0, rom[1][22:8], rom[1][7:0]});
    exp_q.push_back({1'b0, rom[2][22:8], rom[2][7:0]});
    @(negedge spi_clk);
    init_start = 1'b1;
    host_rd = 1'b0; host_addr = a15; host_wdata = d8; host_req = 1'b1;
    @(negedge spi_clk);
    init_start = 1'b0;
    wait_ack(rdv, erv, lat);
    check_eq("contention_host_err", 64'(erv), 64'd0);
    wait_init_idle();
    init_check(1'b0);

    // async reset during WAIT_FIN, then recovery
    host_xact(1'b1, 15'h1357, 8'h00, 8'h3C, 1, 1'b0);
    fin_delay = -1;
    base = n_rise;
    @(negedge spi_clk);
    host_rd = 1'b1; host_addr = 15'h4321; host_wdata = 8'h77; host_req = 1'b1;
    exp_q.push_back({1'b1, 15'h4321, 8'h77});
    for (int n = 0; n < 100 && n_rise == base; n++) @(negedge spi_clk);
    repeat (10) @(negedge spi_clk);
    @(posedge spi_clk);
    #3;
    spi_reset_n = 1'b0;
    host_req = 1'b0;
    #1;
    check_eq("async_reset_outputs", 64'({init_busy, init_done, init_err, rom_addr, host_ack, host_err,
             host_rdata, m_wr_en, m_rd_en, m_cmd, m_addr, m_din}), 64'd0);
    check_eq("async_reset_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge spi_clk);
    spi_reset_n = 1'b1;
    last_rdata = '0;
    host_xact(1'b0, 15'h0ACE, 8'hE7, 8'h00, 1, 1'b0);
    host_xact(1'b1, 15'h0BEE, 8'h00, 8'h6D, 3, 1'b0);
    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
